axi_lite_apb_multi_bridge: RTL and testbench

//  AXI4-Lite slave to APB4 master bridge with NUM_SLAVES decoded APB targets.

---
 rtl/apb_bridge_pkg.sv | 18 +
 rtl/apb_addr_decode.sv | 22 ++
 rtl/axi_lite_apb_multi_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_apb_multi_bridge.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared constants and helpers for the AXI4-Lite to APB4 multi-target bridge.
package apb_bridge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Width of a slave index; never zero so a single target still has a usable select
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the 4-bit region field of an address to a one-hot PSEL vector, index and miss flag.
module apb_addr_decode
   import apb_bridge_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned IDX_W      = idx_w(NUM_SLAVES)
) (
   input  logic [3:0]            field,
   output logic [NUM_SLAVES-1:0] sel,
   output logic [IDX_W-1:0]      idx,
   output logic                  miss
);

   always_comb begin
      miss = ({1'b0, field} >= 5'(NUM_SLAVES));
      idx  = field[IDX_W-1:0];
      sel  = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         sel[i] = !miss && (field == 4'(i));
   end

endmodule

// File: rtl/axi_lite_apb_multi_bridge.sv
// AXI4-Lite slave to APB4 master bridge with NUM_SLAVES decoded targets.
// Optional `APB_TIMEOUT_EN bounds the ACCESS phase and answers SLVERR on expiry.
module axi_lite_apb_multi_bridge
   import apb_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_SLAVES  = 4,
   parameter int unsigned SLV_AW      = 12,
   parameter int unsigned TIMEOUT_CYC = 64,
   localparam int unsigned STRB_W     = DATA_W / 8
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [ADDR_W-1:0]            AWADDR,
   input  logic                         AWVALID,
   output logic                         AWREADY,
   input  logic [DATA_W-1:0]            WDATA,
   input  logic [STRB_W-1:0]            WSTRB,
   input  logic                         WVALID,
   output logic                         WREADY,
   output logic [1:0]                   BRESP,
   output logic                         BVALID,
   input  logic                         BREADY,
   input  logic [ADDR_W-1:0]            ARADDR,
   input  logic                         ARVALID,
   output logic                         ARREADY,
   output logic [DATA_W-1:0]            RDATA,
   output logic [1:0]                   RRESP,
   output logic                         RVALID,
   input  logic                         RREADY,
   output logic [ADDR_W-1:0]            PADDR,
   output logic [NUM_SLAVES-1:0]        PSEL,
   output logic                         PENABLE,
   output logic                         PWRITE,
   output logic [DATA_W-1:0]            PWDATA,
   output logic [STRB_W-1:0]            PSTRB,
   input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]        PREADY,
   input  logic [NUM_SLAVES-1:0]        PSLVERR,
   output logic                         error
);

   localparam int unsigned IDX_W = idx_w(NUM_SLAVES);

   logic [1:0]            state_q, state_d;
   logic                  run_q, aw_held, w_held, ar_held, rd_prio_q;
   logic [ADDR_W-1:0]     awaddr_q, araddr_q, req_addr;
   logic [DATA_W-1:0]     wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [IDX_W-1:0]      sel_idx_q, dec_idx;
   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  dec_miss, wr_req, rd_req, grant_wr, start;
   logic                  pready_sel, pslverr_sel, tmo_hit, acc_done;
   logic [1:0]            acc_resp;
   logic [DATA_W-1:0]     prdata_arr [NUM_SLAVES];

   // run_q keeps all READYs low while reset is asserted
   assign AWREADY = run_q && !aw_held && (state_q == ST_IDLE);
   assign WREADY  = run_q && !w_held  && (state_q == ST_IDLE);
   assign ARREADY = run_q && !ar_held && (state_q == ST_IDLE);

   // Priority flips only when both directions contend; reset favours reads
   assign wr_req   = aw_held && w_held;
   assign rd_req   = ar_held;
   assign grant_wr = wr_req && (!rd_req || !rd_prio_q);
   assign req_addr = grant_wr ? awaddr_q : araddr_q;
   assign start    = (state_q == ST_IDLE) && (wr_req || rd_req);

   apb_addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .IDX_W      (IDX_W)
   ) u_decode (
      .field (req_addr[SLV_AW+3 -: 4]),
      .sel   (dec_sel),
      .idx   (dec_idx),
      .miss  (dec_miss)
   );

   always_comb begin
      for (int i = 0; i < NUM_SLAVES; i++)
         prdata_arr[i] = PRDATA[i*DATA_W +: DATA_W];
   end

   assign pready_sel  = PREADY[sel_idx_q];
   assign pslverr_sel = PSLVERR[sel_idx_q];
   assign acc_done    = (state_q == ST_ACCESS) && (pready_sel || tmo_hit);
   assign acc_resp    = (tmo_hit || pslverr_sel) ? RESP_SLVERR : RESP_OKAY;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)                     tmo_q <= '0;
      else if (state_q == ST_ACCESS)  tmo_q <= tmo_q + TMO_W'(1);
      else                            tmo_q <= '0;
   end

   assign tmo_hit = (state_q == ST_ACCESS) && !pready_sel &&
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
   logic unused_tmo_cfg;
   assign tmo_hit        = 1'b0;
   assign unused_tmo_cfg = |TIMEOUT_CYC;
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = dec_miss ? ST_RESP : ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (acc_done) state_d = ST_RESP;
         default:   if ((BVALID && BREADY) || (RVALID && RREADY)) state_d = ST_IDLE;
      endcase
   end

   // AXI request holding registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         run_q     <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         ar_held   <= 1'b0;
         rd_prio_q <= 1'b1;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         run_q <= 1'b1;
         if (AWVALID && AWREADY) begin
            aw_held  <= 1'b1;
            awaddr_q <= AWADDR;
         end else if (start && grant_wr) begin
            aw_held  <= 1'b0;
         end
         if (WVALID && WREADY) begin
            w_held  <= 1'b1;
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
         end else if (start && grant_wr) begin
            w_held  <= 1'b0;
         end
         if (ARVALID && ARREADY) begin
            ar_held  <= 1'b1;
            araddr_q <= ARADDR;
         end else if (start && !grant_wr) begin
            ar_held  <= 1'b0;
         end
         if (start && wr_req && rd_req) rd_prio_q <= grant_wr;
      end
   end

   // APB drive and AXI response registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         PADDR     <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         sel_idx_q <= '0;
         BVALID    <= 1'b0;
         BRESP     <= RESP_OKAY;
         RVALID    <= 1'b0;
         RRESP     <= RESP_OKAY;
         RDATA     <= '0;
         error     <= 1'b0;
      end else begin
         error <= 1'b0;
         if (BVALID && BREADY) BVALID <= 1'b0;
         if (RVALID && RREADY) RVALID <= 1'b0;
         if (start) begin
            if (dec_miss) begin
               error <= 1'b1;
               if (grant_wr) begin
                  BVALID <= 1'b1;
                  BRESP  <= RESP_DECERR;
               end else begin
                  RVALID <= 1'b1;
                  RRESP  <= RESP_DECERR;
                  RDATA  <= '0;
               end
            end else begin
               PSEL      <= dec_sel;
               PADDR     <= req_addr;
               PWRITE    <= grant_wr;
               PWDATA    <= grant_wr ? wdata_q : '0;
               PSTRB     <= grant_wr ? wstrb_q : '0;
               sel_idx_q <= dec_idx;
            end
         end
         if (state_q == ST_SETUP) PENABLE <= 1'b1;
         if (acc_done) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            error   <= (acc_resp != RESP_OKAY);
            if (PWRITE) begin
               BVALID <= 1'b1;
               BRESP  <= acc_resp;
            end else begin
               RVALID <= 1'b1;
               RRESP  <= acc_resp;
               RDATA  <= tmo_hit ? '0 : prdata_arr[sel_idx_q];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_apb_multi_bridge.sv
// Directed self-checking bench for axi_lite_apb_multi_bridge with a 4-target APB memory model.
module tb_axi_lite_apb_multi_bridge;

   logic         ACLK = 1'b0;
   logic         ARESET;
   logic [31:0]  AWADDR, ARADDR, WDATA, RDATA, PADDR, PWDATA;
   logic [3:0]   WSTRB, PSTRB, PSEL, PREADY, PSLVERR;
   logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic         ARVALID, ARREADY, RVALID, RREADY, PENABLE, PWRITE, error;
   logic [1:0]   BRESP, RRESP;
   logic [127:0] PRDATA;

   int n_chk = 0;
   int n_fail = 0;

   int   wait_cfg = 0;
   int   wait_cnt = 0;
   logic hang = 1'b0;
   logic slverr_cfg = 1'b0;
   logic [31:0] mem [4][4] = '{default: '0};

   always #5 ACLK = ~ACLK;

   axi_lite_apb_multi_bridge dut (
      .ACLK (ACLK), .ARESET (ARESET),
      .AWADDR (AWADDR), .AWVALID (AWVALID), .AWREADY (AWREADY),
      .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
      .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
      .ARADDR (ARADDR), .ARVALID (ARVALID), .ARREADY (ARREADY),
      .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
      .PADDR (PADDR), .PSEL (PSEL), .PENABLE (PENABLE), .PWRITE (PWRITE),
      .PWDATA (PWDATA), .PSTRB (PSTRB), .PRDATA (PRDATA),
      .PREADY (PREADY), .PSLVERR (PSLVERR), .error (error)
   );

   // APB targets: word memory per slave, wait_cfg wait states, hang suppresses PREADY
   always @(negedge ACLK) begin
      int slv;
      logic [1:0] w;
      slv = 0;
      for (int i = 0; i < 4; i++) if (PSEL[i]) slv = i;
      w = PADDR[3:2];
      PREADY  = '0;
      PSLVERR = '0;
      for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = 32'hBAD0_0000 + 32'(i);
      if ((|PSEL) && PENABLE && !hang) begin
         if (wait_cnt >= wait_cfg) begin
            wait_cnt      = 0;
            PREADY[slv]   = 1'b1;
            PSLVERR[slv]  = slverr_cfg;
            if (PWRITE) begin
               for (int b = 0; b < 4; b++)
                  if (PSTRB[b]) mem[slv][w][b*8 +: 8] = PWDATA[b*8 +: 8];
            end else begin
               PRDATA[slv*32 +: 32] = mem[slv][w];
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic aw_f, w_f;
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = 1'b1; WVALID = 1'b1;
      for (int k = 0; k < 100 && (AWVALID || WVALID); k++) begin
         aw_f = AWVALID && AWREADY;
         w_f  = WVALID && WREADY;
         tick();
         if (aw_f) AWVALID = 1'b0;
         if (w_f)  WVALID  = 1'b0;
      end
      chk("aw_w_accepted", {AWVALID, WVALID}, 0);
      AWVALID = 1'b0; WVALID = 1'b0;
   endtask

   task automatic send_read(input logic [31:0] a);
      logic ar_f;
      ARADDR = a; ARVALID = 1'b1;
      for (int k = 0; k < 100 && ARVALID; k++) begin
         ar_f = ARVALID && ARREADY;
         tick();
         if (ar_f) ARVALID = 1'b0;
      end
      chk("ar_accepted", ARVALID, 0);
      ARVALID = 1'b0;
   endtask

   task automatic wait_b(output logic [1:0] resp, output int lat);
      lat = 0;
      while (!BVALID && lat < 200) begin tick(); lat++; end
      chk("bvalid_seen", BVALID, 1);
      resp = BRESP;
   endtask

   task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output int lat);
      lat = 0;
      while (!RVALID && lat < 200) begin tick(); lat++; end
      chk("rvalid_seen", RVALID, 1);
      data = RDATA;
      resp = RRESP;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
      send_write(a, d, s);
      wait_b(resp, lat);
      BREADY = 1'b1; tick(); BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
      send_read(a);
      wait_r(data, resp, lat);
      RREADY = 1'b1; tick(); RREADY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  resp, ord;
      logic [31:0] data, rd_seen;
      int          lat, nseen, stray;

      ARESET = 1'b1;
      AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
      AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
      tick(); tick();
      chk("rst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, PSEL, PENABLE, PWRITE, error}, 0);
      chk("rst_data", {PADDR, PWDATA}, 0);
      chk("rst_misc", {PSTRB, RDATA, BRESP, RRESP}, 0);
      ARESET = 1'b0;
      tick();
      chk("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

      // Test 1: single write, cycle-exact APB timing
      AWADDR = 32'h4000_0004; WDATA = 32'h0000_00A5; WSTRB = 4'b0001;
      AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      chk("t1_held_awready", {AWREADY, WREADY}, 0);
      chk("t1_idle_psel", PSEL, 0);
      tick();
      chk("t1_setup_ctrl", {PSEL, PENABLE, PWRITE}, {4'b0001, 1'b0, 1'b1});
      chk("t1_setup_paddr", PADDR, 32'h4000_0004);
      chk("t1_setup_pwdata", PWDATA, 32'h0000_00A5);
      chk("t1_setup_pstrb", PSTRB, 4'b0001);
      tick();
      chk("t1_access", {PSEL, PENABLE}, {4'b0001, 1'b1});
      tick();
      chk("t1_bresp", {BVALID, BRESP, PSEL, PENABLE}, {1'b1, 2'b00, 4'b0000, 1'b0});
      BREADY = 1'b1; tick(); BREADY = 1'b0;
      chk("t1_b_done", BVALID, 0);

      // Test 2: write then read slave 1 with 3 wait states
      do_write(32'h4000_1004, 32'hDEAD_BEEF, 4'hF, resp, lat);
      chk("t2_wresp", resp, 2'b00);
      chk("t2_wlat", 64'(lat), 3);
      wait_cfg = 3;
      do_read(32'h4000_1004, data, resp, lat);
      wait_cfg = 0;
      chk("t2_rdata", data, 32'hDEAD_BEEF);
      chk("t2_rresp", resp, 2'b00);
      chk("t2_rlat", 64'(lat), 6);
      do_read(32'h4000_0004, data, resp, lat);
      chk("t2_strobe_rdata", data, 32'h0000_00A5);

      // Test 3: simultaneous AW/W/AR twice; read wins first, write wins the second contest
      for (int pair = 0; pair < 2; pair++) begin
         AWADDR = (pair == 0) ? 32'h4000_2008 : 32'h4000_3000;
         WDATA  = (pair == 0) ? 32'h1111_2222 : 32'h3333_3333;
         WSTRB  = 4'hF;
         ARADDR = (pair == 0) ? 32'h4000_0004 : 32'h4000_2008;
         AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
         BREADY = 1'b1; RREADY = 1'b1;
         chk("t3_all_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
         tick();
         AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
         nseen = 0; ord = '0; rd_seen = '0;
         for (int k = 0; k < 30; k++) begin
            if ((|PSEL) && !PENABLE) begin
               if (nseen < 2) ord[nseen] = PWRITE;
               nseen++;
            end
            if (RVALID) rd_seen = RDATA;
            tick();
         end
         BREADY = 1'b0; RREADY = 1'b0;
         chk("t3_transfers", 64'(nseen), 2);
         if (pair == 0) begin
            chk("t3_p1_order", {ord[0], ord[1]}, 2'b01);
            chk("t3_p1_rdata", rd_seen, 32'h0000_00A5);
         end else begin
            chk("t3_p2_order", {ord[0], ord[1]}, 2'b10);
            chk("t3_p2_rdata", rd_seen, 32'h1111_2222);
         end
      end

      // Test 4: decode error, no APB cycle, response one cycle after the request
      AWADDR = 32'h4000_F000; WDATA = 32'h77; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      tick();
      chk("t4_decerr", {BVALID, BRESP, error, PSEL}, {1'b1, 2'b11, 1'b1, 4'b0000});
      tick();
      chk("t4_hold", {BVALID, BRESP, error, PSEL, PENABLE}, {1'b1, 2'b11, 1'b0, 4'b0000, 1'b0});
      BREADY = 1'b1; tick(); BREADY = 1'b0;
      chk("t4_b_done", BVALID, 0);
      do_read(32'h4000_4000, data, resp, lat);
      chk("t4_rd_decerr", {resp, data}, {2'b11, 32'h0});
      chk("t4_rd_lat", 64'(lat), 1);
      do_read(32'h0001_1004, data, resp, lat);
      chk("t4_upper_bits_ignored", {resp, data}, {2'b00, 32'hDEAD_BEEF});

      // Test 5: PSLVERR on read, then held write response under BREADY low
      slverr_cfg = 1'b1;
      do_read(32'h4000_1004, data, resp, lat);
      chk("t5_rd_slverr", {resp, data}, {2'b10, 32'hDEAD_BEEF});
      send_write(32'h4000_0008, 32'h55, 4'hF);
      wait_b(resp, lat);
      slverr_cfg = 1'b0;
      chk("t5_wr_slverr_pulse", {resp, error}, 3'b101);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t5_b_hold", {BVALID, BRESP, error}, 4'b1100);
      end
      BREADY = 1'b1; tick(); BREADY = 1'b0;
      chk("t5_b_done", BVALID, 0);

`ifdef APB_TIMEOUT_EN
      // Test 6a: target never ready, timeout answers SLVERR with zero data
      hang = 1'b1;
      do_read(32'h4000_2008, data, resp, lat);
      hang = 1'b0;
      chk("t6_tmo_resp", {resp, data}, {2'b10, 32'h0});
      chk("t6_tmo_lat", 64'(lat), 66);
`endif

      // Test 6b: async reset in ACCESS aborts the transfer with no response
      hang = 1'b1;
      send_read(32'h4000_0000);
      tick(); tick();
      chk("t6_in_access", {PSEL, PENABLE}, {4'b0001, 1'b1});
      ARESET = 1'b1;
      #1;
      chk("t6_rst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, PSEL, PENABLE, PWRITE, error}, 0);
      chk("t6_rst_data", {PADDR, PWDATA}, 0);
      chk("t6_rst_misc", {PSTRB, RDATA, BRESP, RRESP}, 0);
      tick();
      ARESET = 1'b0;
      hang = 1'b0;
      stray = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (RVALID || BVALID || (|PSEL)) stray++;
      end
      chk("t6_no_resp_after_reset", 64'(stray), 0);
      chk("t6_ready_again", ARREADY, 1);
      do_read(32'h4000_1004, data, resp, lat);
      chk("t6_recover", {resp, data}, {2'b00, 32'hDEAD_BEEF});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
